// File: rtl/uart16550_rx_deser.sv
// -----------------------------------------------------------------------------
// uart16550_rx_deser
//
// Receive-side serial deserialiser of a 16550-compatible UART.
// The serial input (or the internal loopback line) is synchronised, start bits
// are found with baud-tick oversampling, and 5..8 data bits are shifted in LSB
// first. Parity, stop and break are then checked. One status-tagged character
// is pushed per frame; q_o feeds the Rx FIFO data input.
//
// Optional build macro:
//   RX_MAJORITY_VOTE_EN  each bit value is the 2-of-3 majority of the samples
//                        at mid-1, mid and mid+1; the decision is taken at the
//                        mid+1 tick. Undefined: a single sample at mid-bit.
//
// Parameters:
//   OVERSAMPLE   baud_tick_i pulses per bit (power of 2, >= 8)
//
// Ports:
//   clk_i        core clock, rising edge
//   rst_ni       synchronous active-low reset
//   baud_tick_i  one-clk-wide oversampling enable
//   sin_i        asynchronous serial input, idle high
//   loop_i       1 = receive from loop_sin_i instead of sin_i
//   loop_sin_i   internal transmitter output for loopback
//   wls_i        word length select, 0..3 -> 5..8 data bits
//   pen_i        parity enable
//   eps_i        even parity select
//   sp_i         stick parity
//   push_o       one-clk pulse, q_o valid for the Rx FIFO
//   q_o          {bi, fe, pe, data[7:0]}; unused upper data bits are 0
//   busy_o       1 while a frame is being received
// -----------------------------------------------------------------------------
module uart16550_rx_deser #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        baud_tick_i,
  input  logic        sin_i,
  input  logic        loop_i,
  input  logic        loop_sin_i,
  input  logic [1:0]  wls_i,
  input  logic        pen_i,
  input  logic        eps_i,
  input  logic        sp_i,
  output logic        push_o,
  output logic [10:0] q_o,
  output logic        busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_VOTE_EN
  // Decision one tick after mid-bit so that the mid+1 sample is available.
  localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      data_reg;
  logic            par_bit_reg;
  logic            pe_reg;
  logic [1:0]      wls_cfg_reg;
  logic            pen_cfg_reg;
  logic            eps_cfg_reg;
  logic            sp_cfg_reg;
  logic            sync1_reg;
  logic            rxd_reg;

  logic            line_in;
  logic            bit_val;
  logic            exp_par;
  logic            break_det;
  logic [2:0]      last_bit;

  assign line_in = loop_i ? loop_sin_i : sin_i;

  // Two-flop synchroniser; runs every clock, independent of the baud tick.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_reg <= 1'b1;
      rxd_reg   <= 1'b1;
    end else begin
      sync1_reg <= line_in;
      rxd_reg   <= sync1_reg;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  // hist_reg[1] = sample two ticks ago (mid-1), hist_reg[0] = previous tick (mid).
  logic [1:0] hist_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_reg <= 2'b11;
    end else if (baud_tick_i) begin
      hist_reg <= {hist_reg[0], rxd_reg};
    end
  end

  assign bit_val = (hist_reg[1] & hist_reg[0]) |
                   (hist_reg[1] & rxd_reg) |
                   (hist_reg[0] & rxd_reg);
`else
  assign bit_val = rxd_reg;
`endif

  // Index of the final data bit for the frozen word length.
  assign last_bit = 3'd4 + {1'b0, wls_cfg_reg};

  // Stick parity forces a constant; otherwise the parity bit makes the
  // total count of ones even (eps=1) or odd (eps=0).
  assign exp_par = sp_cfg_reg ? ~eps_cfg_reg : (^data_reg ^ ~eps_cfg_reg);

  // Evaluated at the stop-sample tick: all-zero data, parity and stop.
  assign break_det = (data_reg == 8'h00) &&
                     (!pen_cfg_reg || !par_bit_reg) &&
                     !bit_val;

  assign busy_o = (state_reg != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= S_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= 3'd0;
      data_reg     <= 8'h00;
      par_bit_reg  <= 1'b0;
      pe_reg       <= 1'b0;
      wls_cfg_reg  <= 2'd0;
      pen_cfg_reg  <= 1'b0;
      eps_cfg_reg  <= 1'b0;
      sp_cfg_reg   <= 1'b0;
      push_o       <= 1'b0;
      q_o          <= 11'h000;
    end else begin
      push_o <= 1'b0;
      if (baud_tick_i) begin
        // Free-running wrap; OVERSAMPLE is a power of two.
        tick_cnt_reg <= tick_cnt_reg + TW'(1);
        case (state_reg)
          S_IDLE: begin
            if (!rxd_reg) begin
              tick_cnt_reg <= '0;
              wls_cfg_reg  <= wls_i;
              pen_cfg_reg  <= pen_i;
              eps_cfg_reg  <= eps_i;
              sp_cfg_reg   <= sp_i;
              state_reg    <= S_START;
            end
          end
          S_START: begin
            if (tick_cnt_reg == START_TICK) begin
              if (bit_val) begin
                state_reg <= S_IDLE;
              end else begin
                // Re-centre the tick counter on the middle of the start bit.
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= 3'd0;
                data_reg     <= 8'h00;
                par_bit_reg  <= 1'b0;
                pe_reg       <= 1'b0;
                state_reg    <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (tick_cnt_reg == TICK_LAST) begin
              data_reg[bit_cnt_reg] <= bit_val;
              bit_cnt_reg           <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == last_bit) begin
                state_reg <= pen_cfg_reg ? S_PARITY : S_STOP;
              end
            end
          end
          S_PARITY: begin
            if (tick_cnt_reg == TICK_LAST) begin
              par_bit_reg <= bit_val;
              pe_reg      <= (bit_val != exp_par);
              state_reg   <= S_STOP;
            end
          end
          S_STOP: begin
            if (tick_cnt_reg == TICK_LAST) begin
              push_o <= 1'b1;
              q_o    <= {break_det, ~bit_val, pe_reg,
                         break_det ? 8'h00 : data_reg};
              // From here on a new start bit may be detected.
              state_reg <= break_det ? S_BREAK : S_IDLE;
            end
          end
          S_BREAK: begin
            // One character per break: hold off until the line returns high.
            if (rxd_reg) begin
              state_reg <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart16550_rx_deser.sv
`timescale 1ns/1ps
module tb_uart16550_rx_deser;

  localparam int OS = 16;

  logic        clk_i       = 1'b0;
  logic        rst_ni      = 1'b0;
  logic        baud_tick_i = 1'b0;
  logic        sin_i       = 1'b1;
  logic        loop_i      = 1'b0;
  logic        loop_sin_i  = 1'b1;
  logic [1:0]  wls_i       = 2'd3;
  logic        pen_i       = 1'b0;
  logic        eps_i       = 1'b0;
  logic        sp_i        = 1'b0;
  logic        push_o;
  logic [10:0] q_o;
  logic        busy_o;

  int total    = 0;
  int bad      = 0;
  int push_cnt = 0;
  int div      = 1;

  logic [10:0] exp_q[$];

  typedef struct {
    bit          lp;
    logic [1:0]  wls;
    logic        pen;
    logic        eps;
    logic        sp;
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[13];

  always #5 clk_i = ~clk_i;

  uart16550_rx_deser #(.OVERSAMPLE(OS)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .baud_tick_i (baud_tick_i),
    .sin_i       (sin_i),
    .loop_i      (loop_i),
    .loop_sin_i  (loop_sin_i),
    .wls_i       (wls_i),
    .pen_i       (pen_i),
    .eps_i       (eps_i),
    .sp_i        (sp_i),
    .push_o      (push_o),
    .q_o         (q_o),
    .busy_o      (busy_o)
  );

  // Baud tick: one pulse every div clocks, updated just after the edge.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      cnt = (cnt + 1 >= div) ? 0 : cnt + 1;
      baud_tick_i = (cnt == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: every push must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (push_o === 1'b1) begin
      logic [10:0] e;
      push_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_push actual=%h required=none", q_o);
      end else begin
        e = exp_q.pop_front();
        $display("push q=%h expected=%h", q_o, e);
        check("push_q", {21'd0, q_o}, {21'd0, e});
        // Only a break leaves the receiver busy (waiting for line high).
        check("busy_at_push", {31'd0, busy_o}, {31'd0, e[10]});
      end
    end
  end

  // Reference: frame-level meaning of each field.
  function automatic logic [10:0] model_q(input logic [1:0] wls, input logic pen,
                                          input logic eps, input logic sp,
                                          input logic [7:0] data, input logic par,
                                          input logic stop);
    int n;
    int ones;
    logic [7:0] d;
    logic want, pe, fe, bi;
    n    = 5 + int'(wls);
    d    = data & 8'((1 << n) - 1);
    ones = $countones(d);
    if (sp)       want = !eps;
    else if (eps) want = (ones % 2) == 1;   // total ones even
    else          want = (ones % 2) == 0;   // total ones odd
    pe = pen && (par != want);
    bi = (d == 8'h00) && (!pen || !par) && !stop;
    fe = !stop;
    return {bi, fe, pe, bi ? 8'h00 : d};
  endfunction

  task automatic set_line(input logic b);
    if (loop_i) begin
      loop_sin_i = b;
      sin_i      = 1'b0;
    end else begin
      sin_i      = b;
      loop_sin_i = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b);
    set_line(b);
    repeat (OS * div) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [1:0] wls, input logic pen, input logic eps,
                            input logic sp, input logic [7:0] data, input logic par,
                            input logic stop);
    wls_i = wls;
    pen_i = pen;
    eps_i = eps;
    sp_i  = sp;
    send_bit(1'b0);
    check("busy_in_frame", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 5 + int'(wls); i++) send_bit(data[i]);
    if (pen) send_bit(par);
    send_bit(stop);
  endtask

`ifdef RX_MAJORITY_VOTE_EN
  task automatic send_glitch_frame(input int off);
    logic [7:0] d;
    d = 8'hA5;
    wls_i = 2'd3;
    pen_i = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        set_line(1'b0);
        repeat (off * div) @(posedge clk_i);
        #1;
        set_line(1'b1);
        repeat (div) @(posedge clk_i);
        #1;
        set_line(1'b0);
        repeat ((OS - off - 1) * div) @(posedge clk_i);
        #1;
      end else begin
        send_bit(d[i]);
      end
    end
    send_bit(1'b1);
  endtask
`endif

  initial begin
    int pc0;
    tbl[0]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 11'h0A5};
    tbl[1]  = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 11'h135};
    tbl[2]  = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'h35, 1'b0, 1'b1, 11'h035};
    tbl[3]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 11'h281};
    tbl[4]  = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 11'h13C};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 11'h01F};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 11'h02A};
    tbl[7]  = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 11'h055};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 11'h000};
    tbl[9]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'h600};
    tbl[10] = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 11'h600};
    tbl[11] = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 11'h300};
    tbl[12] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 11'h0C3};

    // Reset state
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_push", {31'd0, push_o}, 32'd0);
    check("reset_q", {21'd0, q_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    rst_ni = 1'b1;
    send_bit(1'b1);

    // Directed vectors
    for (int r = 0; r < 13; r++) begin
      pc0    = push_cnt;
      loop_i = tbl[r].lp;
      set_line(1'b1);
      $display("row %0d data=%h expected=%h", r, tbl[r].data, tbl[r].exp);
      exp_q.push_back(tbl[r].exp);
      send_frame(tbl[r].wls, tbl[r].pen, tbl[r].eps, tbl[r].sp,
                 tbl[r].data, tbl[r].par, tbl[r].stop);
      send_bit(1'b1);
      send_bit(1'b1);
      check("row_push_count", push_cnt - pc0, 32'd1);
      check("row_drain", exp_q.size(), 32'd0);
      check("row_idle_busy", {31'd0, busy_o}, 32'd0);
      loop_i = 1'b0;
      set_line(1'b1);
      exp_q.delete();
    end

    // False start: 4 ticks low, then high
    pc0   = push_cnt;
    sin_i = 1'b0;
    repeat (4 * div) @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    #1;
    check("false_start_busy", {31'd0, busy_o}, 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    $display("false start pushes=%0d", push_cnt - pc0);
    check("false_start_pushes", push_cnt - pc0, 32'd0);
    check("false_start_idle", {31'd0, busy_o}, 32'd0);

    // Long break (3 frame times) followed by 0x5A 8N1
    pc0 = push_cnt;
    exp_q.push_back(11'h600);
    exp_q.push_back(11'h05A);
    sin_i = 1'b0;
    repeat (3 * 10 * OS * div) @(posedge clk_i);
    #1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(2'd3, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    $display("break sequence pushes=%0d", push_cnt - pc0);
    check("break_pushes", push_cnt - pc0, 32'd2);
    check("break_drain", exp_q.size(), 32'd0);
    exp_q.delete();

    // Reset in the middle of DATA of 0xFF
    pc0   = push_cnt;
    wls_i = 2'd3;
    pen_i = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    sin_i = 1'b1;
    repeat (OS * div / 2) @(posedge clk_i);
    #1;
    check("pre_reset_busy", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check("mid_reset_push", {31'd0, push_o}, 32'd0);
    check("mid_reset_busy", {31'd0, busy_o}, 32'd0);
    check("mid_reset_q", {21'd0, q_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (OS * div / 2) @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    $display("reset sequence pushes=%0d", push_cnt - pc0);
    check("mid_reset_no_push", push_cnt - pc0, 32'd0);

`ifdef RX_MAJORITY_VOTE_EN
    for (int off = 6; off <= 10; off++) begin
      pc0 = push_cnt;
      exp_q.push_back(11'h0A5);
      send_glitch_frame(off);
      send_bit(1'b1);
      send_bit(1'b1);
      check("glitch_pushes", push_cnt - pc0, 32'd1);
      check("glitch_drain", exp_q.size(), 32'd0);
      exp_q.delete();
    end
`endif

    // Randomised frames, several tick rates, random gaps including none
    for (int blk = 0; blk < 3; blk++) begin
      div = blk + 1;
      send_bit(1'b1);
      pc0 = push_cnt;
      for (int k = 0; k < 15; k++) begin
        logic [1:0] w;
        logic pe, ep, st, par, stp;
        logic [7:0] d;
        int gap;
        w   = 2'($urandom_range(0, 3));
        pe  = 1'($urandom_range(0, 1));
        ep  = 1'($urandom_range(0, 1));
        st  = ($urandom_range(0, 3) == 0);
        d   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        par = 1'($urandom_range(0, 1));
        stp = ($urandom_range(0, 7) != 0);
        exp_q.push_back(model_q(w, pe, ep, st, d, par, stp));
        send_frame(w, pe, ep, st, d, par, stp);
        gap = stp ? $urandom_range(0, 2) : $urandom_range(1, 2);
        for (int g = 0; g < gap; g++) send_bit(1'b1);
      end
      send_bit(1'b1);
      send_bit(1'b1);
      check("rand_pushes", push_cnt - pc0, 32'd15);
      check("rand_drain", exp_q.size(), 32'd0);
      exp_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
